// File: rtl/fetch_buf_ifu.sv
// Instruction fetch unit with up to BUF_DEPTH fetches in flight and an in-order instruction FIFO.
// Static branch prediction is compiled in only when IFU_PRDT_EN is defined.
module fetch_buf_ifu #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  BUF_DEPTH   = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'h8000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   ifu_req_valid_o,
    input  logic                   ifu_req_ready_i,
    output logic [PC_WIDTH-1:0]    ifu_req_pc_o,
    input  logic                   ifu_resp_valid_i,
    output logic                   ifu_resp_ready_o,
    input  logic                   ifu_resp_err_i,
    input  logic [INSTR_WIDTH-1:0] ifu_resp_instr_i,
    input  logic                   exu_flush_valid_i,
    input  logic [PC_WIDTH-1:0]    exu_flush_pc_i,
    output logic                   if_valid_o,
    input  logic                   if_ready_i,
    output logic [INSTR_WIDTH-1:0] if_instr_o,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic                   if_prdt_taken_o,
    output logic                   if_err_o
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
        logic                   prdt;
        logic                   err;
    } entry_t;

    entry_t              fifo_mem [BUF_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       fifo_cnt;
    logic [CW-1:0]       out_cnt;
    logic [CW-1:0]       out_cnt_next;
    logic [CW-1:0]       drop_cnt;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] expect_pc;
    logic [0:0]          state;

    logic [CW:0]         credit_used;
    logic                req_fire;
    logic                resp_fire;
    logic                resp_keep;
    logic                push;
    logic                pop;
    logic                head_vld;
    logic                prdt_taken;
    logic [PC_WIDTH-1:0] prdt_target;
    logic                redirect;
    entry_t              head;
    entry_t              wr_entry;

    // Registered counts only: a pop or response this cycle does not free a credit until next cycle
    assign credit_used     = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    assign ifu_req_valid_o = !rst_i && (state == ST_RUN) && !exu_flush_valid_i &&
                             (credit_used < (CW+1)'(BUF_DEPTH));
    assign ifu_req_pc_o    = fetch_pc;
    assign req_fire        = ifu_req_valid_o && ifu_req_ready_i;

    // A response with nothing in flight (e.g. straight after reset) is ignored
    assign ifu_resp_ready_o = 1'b1;
    assign resp_fire        = ifu_resp_valid_i && (out_cnt != '0);
    assign resp_keep        = resp_fire && !exu_flush_valid_i && (drop_cnt == '0);
    assign out_cnt_next     = out_cnt + CW'(req_fire) - CW'(resp_fire);

`ifdef IFU_PRDT_EN
    function automatic logic signed [PC_WIDTH-1:0] imm_j(input logic [31:0] ins);
        logic signed [20:0] raw;
        raw = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        return PC_WIDTH'(raw);
    endfunction

    function automatic logic signed [PC_WIDTH-1:0] imm_b(input logic [31:0] ins);
        logic signed [12:0] raw;
        raw = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return PC_WIDTH'(raw);
    endfunction

    function automatic logic signed [PC_WIDTH-1:0] imm_i(input logic [31:0] ins);
        logic signed [11:0] raw;
        raw = ins[31:20];
        return PC_WIDTH'(raw);
    endfunction

    always_comb begin
        prdt_taken  = 1'b0;
        prdt_target = '0;
        if (!ifu_resp_err_i) begin
            case (ifu_resp_instr_i[6:0])
                7'b1101111: begin
                    prdt_taken  = 1'b1;
                    prdt_target = expect_pc + $unsigned(imm_j(ifu_resp_instr_i[31:0]));
                end
                // Backward conditional branches are predicted taken
                7'b1100011: begin
                    prdt_taken  = ifu_resp_instr_i[31];
                    prdt_target = expect_pc + $unsigned(imm_b(ifu_resp_instr_i[31:0]));
                end
                7'b1100111: begin
                    prdt_taken  = (ifu_resp_instr_i[19:15] == 5'd0);
                    prdt_target = $unsigned(imm_i(ifu_resp_instr_i[31:0]));
                end
                default: begin
                    prdt_taken  = 1'b0;
                    prdt_target = '0;
                end
            endcase
        end
    end
`else
    assign prdt_taken  = 1'b0;
    assign prdt_target = '0;
`endif

    assign redirect = resp_keep && prdt_taken;

    assign head_vld        = (fifo_cnt != '0);
    assign head            = fifo_mem[rd_ptr];
    assign if_valid_o      = head_vld && !exu_flush_valid_i;
    assign if_instr_o      = head_vld ? head.instr : '0;
    assign if_pc_o         = head_vld ? head.pc    : '0;
    assign if_prdt_taken_o = head_vld && head.prdt;
    assign if_err_o        = head_vld && head.err;

    assign push = resp_keep;
    assign pop  = if_valid_o && if_ready_i;

    assign wr_entry.instr = ifu_resp_instr_i;
    assign wr_entry.pc    = expect_pc;
    assign wr_entry.prdt  = prdt_taken;
    assign wr_entry.err   = ifu_resp_err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_RUN;
            fetch_pc  <= RESET_PC;
            expect_pc <= RESET_PC;
            out_cnt   <= '0;
            drop_cnt  <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            out_cnt <= out_cnt_next;
            if (exu_flush_valid_i) begin
                // Everything still in flight belongs to the squashed path
                fetch_pc  <= exu_flush_pc_i;
                expect_pc <= exu_flush_pc_i;
                drop_cnt  <= out_cnt_next;
                state     <= ST_RUN;
                fifo_cnt  <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
            end else begin
                if (redirect) begin
                    fetch_pc  <= prdt_target;
                    expect_pc <= prdt_target;
                    drop_cnt  <= out_cnt_next;
                end else begin
                    if (req_fire)
                        fetch_pc <= fetch_pc + PC_WIDTH'(4);
                    if (resp_keep)
                        expect_pc <= expect_pc + PC_WIDTH'(4);
                    if (resp_fire && (drop_cnt != '0))
                        drop_cnt <= drop_cnt - CW'(1);
                end
                if (resp_keep && ifu_resp_err_i)
                    state <= ST_HALT;
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    // FIFO storage carries data only and is never reset; the outputs are masked by head_vld
    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr] <= wr_entry;
    end

endmodule
